dds_serial_receiver: RTL and testbench

- Responder end of the DDS serial update protocol.
- Oversamples the serial interface on the system clock, decodes write instructions for frequency, phase and amplitude into shadow registers, and transfers them to active outputs on an io_update rising edge.
- Used as a synthesizable DDS stand-in for loopback tests on the FPGA, and as the golden responder in the controller bench.

---
 rtl/dds_pkg.sv | 61 ++++++
 rtl/sync_edge_det.sv | 30 +++
 rtl/dds_serial_receiver.sv | 189 ++++++++++++++++++
 tb/tb_dds_serial_receiver.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS serial update responder.
package dds_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INSTR,
        ST_DATA,
        ST_DRAIN
    } state_t;

    typedef enum logic [1:0] {
        TGT_NONE,
        TGT_FREQ,
        TGT_PHASE,
        TGT_AMP
    } target_t;

    localparam int ADDR_W   = 13;
    localparam int WCODE_W  = 2;
    localparam int INSTR_W  = 1 + WCODE_W + ADDR_W;
    localparam int CNT_W    = 7;

    localparam int FREQ_W   = 48;
    localparam int PHASE_W  = 14;
    localparam int AMP_W    = 10;

    localparam int FREQ_LEN = 48;
    localparam int WORD_LEN = 16;

    localparam logic [ADDR_W-1:0]  FREQ_ADDR  = 13'h01AB;
    localparam logic [ADDR_W-1:0]  PHASE_ADDR = 13'h01AD;
    localparam logic [ADDR_W-1:0]  AMP_ADDR   = 13'h040C;
    localparam logic [WCODE_W-1:0] W_2B       = 2'b01;
    localparam logic [WCODE_W-1:0] W_STREAM   = 2'b11;

    typedef struct packed {
        logic               rw;
        logic [WCODE_W-1:0] w;
        logic [ADDR_W-1:0]  addr;
    } instr_t;

    // Only writes with the W code matching the register width are accepted.
    function automatic target_t decode_instr(instr_t i);
        target_t t;
        t = TGT_NONE;
        if (!i.rw) begin
            if (i.w == W_STREAM && i.addr == FREQ_ADDR)
                t = TGT_FREQ;
            else if (i.w == W_2B && i.addr == PHASE_ADDR)
                t = TGT_PHASE;
            else if (i.w == W_2B && i.addr == AMP_ADDR)
                t = TGT_AMP;
        end
        return t;
    endfunction

    function automatic logic [CNT_W-1:0] payload_len(target_t t);
        return (t == TGT_FREQ) ? CNT_W'(FREQ_LEN) : CNT_W'(WORD_LEN);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer with edge detection taken purely from flop outputs.
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic d_in,
    output logic lvl_out,
    output logic rise_out,
    output logic fall_out
);

    logic [STAGES-1:0] sync_q;
    logic              lvl_d;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sync_q <= '0;
            lvl_d  <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_in};
            lvl_d  <= sync_q[STAGES-1];
        end
    end

    assign lvl_out  = sync_q[STAGES-1];
    assign rise_out = sync_q[STAGES-1] & ~lvl_d;
    assign fall_out = ~sync_q[STAGES-1] & lvl_d;

endmodule

// File: rtl/dds_serial_receiver.sv
// Oversampling DDS serial responder: decodes write frames into shadow registers
// and transfers pending shadows to the active outputs on io_update.
module dds_serial_receiver
    import dds_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 sclk_in,
    input  logic                 csb_in,
    input  logic                 sdio_in,
    input  logic                 io_update_in,
    output logic [FREQ_W-1:0]    freq_out,
    output logic [PHASE_W-1:0]   phase_out,
    output logic [AMP_W-1:0]     amp_out,
    output logic                 freq_upd_out,
    output logic                 phase_upd_out,
    output logic                 amp_upd_out,
    output logic                 frame_err_out,
    output logic [ERR_CNT_W-1:0] err_count_out
);

    logic       sclk_rise, csb_lvl, csb_rise, csb_fall, sdio_lvl, io_rise;
    logic [5:0] unused_edges;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk_in(clk_in), .rst_in(rst_in), .d_in(sclk_in),
        .lvl_out(unused_edges[0]), .rise_out(sclk_rise), .fall_out(unused_edges[1])
    );
    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_csb (
        .clk_in(clk_in), .rst_in(rst_in), .d_in(csb_in),
        .lvl_out(csb_lvl), .rise_out(csb_rise), .fall_out(csb_fall)
    );
    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_sdio (
        .clk_in(clk_in), .rst_in(rst_in), .d_in(sdio_in),
        .lvl_out(sdio_lvl), .rise_out(unused_edges[2]), .fall_out(unused_edges[3])
    );
    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_io (
        .clk_in(clk_in), .rst_in(rst_in), .d_in(io_update_in),
        .lvl_out(unused_edges[4]), .rise_out(io_rise), .fall_out(unused_edges[5])
    );

    state_t               state, state_nx;
    target_t              tgt, tgt_nx;
    logic [CNT_W-1:0]     bit_cnt;
    logic [INSTR_W-2:0]   instr_sr;
    instr_t               instr_nx;
    logic [FREQ_W-1:0]    data_sr;
    logic                 cnt_clr, shift_instr, shift_data, commit, err;
    logic                 commit_f, commit_p, commit_a;

    logic [FREQ_W-1:0]    freq_sh;
    logic [PHASE_W-1:0]   phase_sh;
    logic [AMP_W-1:0]     amp_sh;
    logic                 pend_f, pend_p, pend_a;

    always_comb begin
        state_nx    = state;
        tgt_nx      = tgt;
        cnt_clr     = 1'b0;
        shift_instr = 1'b0;
        shift_data  = 1'b0;
        commit      = 1'b0;
        err         = 1'b0;
        instr_nx    = {instr_sr, sdio_lvl};
        case (state)
            ST_IDLE: begin
                if (csb_fall) begin
                    state_nx = ST_INSTR;
                    cnt_clr  = 1'b1;
                end else if (!csb_lvl) begin
                    // csb already low (e.g. released from reset mid-frame): skip it
                    state_nx = ST_DRAIN;
                end
            end
            ST_INSTR: begin
                if (csb_rise) begin
                    err      = 1'b1;
                    state_nx = ST_IDLE;
                end else if (sclk_rise) begin
                    shift_instr = 1'b1;
                    if (bit_cnt == CNT_W'(INSTR_W - 1)) begin
                        cnt_clr = 1'b1;
                        tgt_nx  = decode_instr(instr_nx);
                        if (tgt_nx == TGT_NONE) begin
                            err      = 1'b1;
                            state_nx = ST_DRAIN;
                        end else begin
                            state_nx = ST_DATA;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (csb_rise) begin
                    if (bit_cnt == payload_len(tgt))
                        commit = 1'b1;
                    else
                        err = 1'b1;
                    state_nx = ST_IDLE;
                end else if (sclk_rise) begin
                    if (bit_cnt == payload_len(tgt)) begin
                        err      = 1'b1;
                        state_nx = ST_DRAIN;
                    end else begin
                        shift_data = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (csb_rise)
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign commit_f = commit && (tgt == TGT_FREQ);
    assign commit_p = commit && (tgt == TGT_PHASE);
    assign commit_a = commit && (tgt == TGT_AMP);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state   <= ST_IDLE;
            tgt     <= TGT_NONE;
            bit_cnt <= '0;
            instr_sr <= '0;
            data_sr <= '0;
        end else begin
            state <= state_nx;
            tgt   <= tgt_nx;
            if (cnt_clr)
                bit_cnt <= '0;
            else if (shift_instr || shift_data)
                bit_cnt <= bit_cnt + CNT_W'(1);
            if (shift_instr)
                instr_sr <= instr_nx[INSTR_W-2:0];
            if (shift_data)
                data_sr <= {data_sr[FREQ_W-2:0], sdio_lvl};
        end
    end

    // A frame committed in the same cycle as an io_update edge stays pending.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            freq_sh       <= '0;
            phase_sh      <= '0;
            amp_sh        <= '0;
            pend_f        <= 1'b0;
            pend_p        <= 1'b0;
            pend_a        <= 1'b0;
            freq_out      <= '0;
            phase_out     <= '0;
            amp_out       <= '0;
            freq_upd_out  <= 1'b0;
            phase_upd_out <= 1'b0;
            amp_upd_out   <= 1'b0;
        end else begin
            if (commit_f) freq_sh  <= data_sr;
            if (commit_p) phase_sh <= data_sr[PHASE_W-1:0];
            if (commit_a) amp_sh   <= data_sr[AMP_W-1:0];

            pend_f <= (pend_f & ~io_rise) | commit_f;
            pend_p <= (pend_p & ~io_rise) | commit_p;
            pend_a <= (pend_a & ~io_rise) | commit_a;

            freq_upd_out  <= io_rise & pend_f;
            phase_upd_out <= io_rise & pend_p;
            amp_upd_out   <= io_rise & pend_a;
            if (io_rise && pend_f) freq_out  <= freq_sh;
            if (io_rise && pend_p) phase_out <= phase_sh;
            if (io_rise && pend_a) amp_out   <= amp_sh;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            frame_err_out <= 1'b0;
            err_count_out <= '0;
        end else begin
            frame_err_out <= err;
            if (err && (err_count_out != '1))
                err_count_out <= err_count_out + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dds_serial_receiver.sv
// Scoreboard bench: frame-level reference model pushes expected strobe events,
// a negedge monitor pops and compares whenever the DUT strobes.
module tb_dds_serial_receiver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0, csb = 1'b1, sdio = 1'b0, io = 1'b0;
    logic [47:0] freq_out;
    logic [13:0] phase_out;
    logic [9:0]  amp_out;
    logic        freq_upd, phase_upd, amp_upd, frame_err;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    dds_serial_receiver #(.SYNC_STAGES(2), .ERR_CNT_W(8)) dut (
        .clk_in(clk), .rst_in(rst), .sclk_in(sclk), .csb_in(csb), .sdio_in(sdio),
        .io_update_in(io), .freq_out(freq_out), .phase_out(phase_out), .amp_out(amp_out),
        .freq_upd_out(freq_upd), .phase_upd_out(phase_upd), .amp_upd_out(amp_upd),
        .frame_err_out(frame_err), .err_count_out(err_count)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          f, p, a, e;
        logic [47:0] fv;
        logic [13:0] pv;
        logic [9:0]  av;
        logic [7:0]  ec;
        int          due;
    } ev_t;
    ev_t exp_q[$];

    // reference model state
    logic [47:0] m_fsh, m_fout;
    logic [13:0] m_psh, m_pout;
    logic [9:0]  m_ash, m_aout;
    bit          m_pf, m_pp, m_pa;
    int          m_ec;

    function automatic void model_reset();
        m_fsh = '0; m_fout = '0; m_psh = '0; m_pout = '0; m_ash = '0; m_aout = '0;
        m_pf = 0; m_pp = 0; m_pa = 0; m_ec = 0;
    endfunction

    function automatic void push_ev(bit f, bit p, bit a, bit e, int due);
        ev_t ev;
        ev.f = f; ev.p = p; ev.a = a; ev.e = e;
        ev.fv = m_fout; ev.pv = m_pout; ev.av = m_aout; ev.ec = 8'(m_ec); ev.due = due;
        exp_q.push_back(ev);
    endfunction

    // io_update in the model: every pending field moves to its output together
    function automatic void model_io(int due);
        if (m_pf || m_pp || m_pa) begin
            if (m_pf) m_fout = m_fsh;
            if (m_pp) m_pout = m_psh;
            if (m_pa) m_aout = m_ash;
            push_ev(m_pf, m_pp, m_pa, 1'b0, due);
            m_pf = 0; m_pp = 0; m_pa = 0;
        end
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h need %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (freq_upd || phase_upd || amp_upd || frame_err)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe: got f%0b p%0b a%0b e%0b at cyc %0d, need none",
                         freq_upd, phase_upd, amp_upd, frame_err, cyc);
            end else begin
                ev_t ev;
                ev = exp_q.pop_front();
                if (freq_upd !== ev.f || phase_upd !== ev.p || amp_upd !== ev.a ||
                    frame_err !== ev.e || freq_out !== ev.fv || phase_out !== ev.pv ||
                    amp_out !== ev.av || err_count !== ev.ec || (ev.due >= 0 && cyc != ev.due)) begin
                    bad++;
                    $display("FAIL strobe_event: got f%0b p%0b a%0b e%0b freq=%h phase=%h amp=%h cnt=%0d cyc=%0d need f%0b p%0b a%0b e%0b freq=%h phase=%h amp=%h cnt=%0d cyc=%0d",
                             freq_upd, phase_upd, amp_upd, frame_err, freq_out, phase_out, amp_out,
                             err_count, cyc, ev.f, ev.p, ev.a, ev.e, ev.fv, ev.pv, ev.av, ev.ec, ev.due);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sclk = 1'b0; sdio = b; tick(3);
        sclk = 1'b1; tick(3);
    endtask

    // Sends ibits of instr then plen payload bits; model outcome is decided up front.
    task automatic do_frame(input logic [15:0] instr, input int ibits, input int plen,
                            input logic [63:0] payload, input bit io_at_end);
        int fld, exp_len, c0;
        bit ok;
        fld = 0;
        if (!instr[15] && instr[14:13] == 2'b11 && instr[12:0] == 13'h01AB) fld = 1;
        else if (!instr[15] && instr[14:13] == 2'b01 && instr[12:0] == 13'h01AD) fld = 2;
        else if (!instr[15] && instr[14:13] == 2'b01 && instr[12:0] == 13'h040C) fld = 3;
        exp_len = (fld == 1) ? 48 : 16;
        ok = (ibits == 16) && (fld != 0) && (plen == exp_len);
        if (!ok) begin
            m_ec = (m_ec == 255) ? 255 : m_ec + 1;
            push_ev(1'b0, 1'b0, 1'b0, 1'b1, -1);
        end
        csb = 1'b0; tick(3);
        for (int i = 0; i < ibits; i++) send_bit(instr[15-i]);
        if (ibits == 16)
            for (int i = 0; i < plen; i++) send_bit(payload[plen-1-i]);
        sclk = 1'b0; tick(3);
        c0 = cyc;
        if (io_at_end) begin
            model_io(c0 + 3);
            io = 1'b1;
        end
        csb = 1'b1;
        if (ok) begin
            if (fld == 1) begin m_fsh = payload[47:0]; m_pf = 1; end
            if (fld == 2) begin m_psh = payload[13:0]; m_pp = 1; end
            if (fld == 3) begin m_ash = payload[9:0];  m_pa = 1; end
        end
        tick(6);
        io = 1'b0;
        tick(4);
    endtask

    task automatic do_io();
        model_io(cyc + 3);
        io = 1'b1; tick(5);
        io = 1'b0; tick(4);
    endtask

    initial begin
        logic [15:0] ins;
        logic [63:0] pl;
        int kind, plen, ib;

        model_reset();
        tick(3);
        rst = 1'b0;
        tick(8);
        chk("rst_freq", freq_out, 0);
        chk("rst_phase", phase_out, 0);
        chk("rst_amp", amp_out, 0);
        chk("rst_errcnt", err_count, 0);
        chk("rst_strobes", {freq_upd, phase_upd, amp_upd, frame_err}, 0);

        // freq frame then io_update; latency is checked through the event due cycle
        do_frame(16'h61AB, 16, 48, 64'h123456789ABC, 0);
        do_io();
        chk("freq_value", freq_out, 64'h123456789ABC);

        // phase + amp committed together
        do_frame(16'h21AD, 16, 16, 64'h2ABC, 0);
        do_frame(16'h240C, 16, 16, 64'h03FF, 0);
        do_io();

        // truncated freq frame: error, nothing pending
        do_frame(16'h61AB, 16, 40, 64'hFF_FFFF_FFFF, 0);
        do_io();
        chk("trunc_errcnt", err_count, 1);
        chk("trunc_freq_hold", freq_out, 64'h123456789ABC);

        // read bit and unknown address, then a valid amp frame
        do_frame(16'hA1AD, 16, 16, 64'h1111, 0);
        do_frame(16'h2000, 16, 16, 64'h2222, 0);
        chk("bad_instr_errcnt", err_count, 3);
        do_frame(16'h240C, 16, 16, 64'h0155, 0);
        do_io();
        chk("amp_after_err", amp_out, 64'h155);

        // commit coincident with io_update: only older pending phase moves
        do_frame(16'h21AD, 16, 16, 64'h1234, 0);
        do_frame(16'h240C, 16, 16, 64'h02AA, 1);
        chk("coincident_amp_hold", amp_out, 64'h155);
        do_io();
        chk("coincident_amp_next", amp_out, 64'h2AA);

        // reset at bit 20 of a freq frame, released with csb low
        tick(10);
        csb = 1'b0; tick(3);
        for (int i = 0; i < 16; i++) send_bit(ins_freq(i));
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rst = 1'b1; model_reset(); tick(2);
        rst = 1'b0; tick(8);
        chk("midrst_freq", freq_out, 0);
        chk("midrst_errcnt", err_count, 0);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        sclk = 1'b0; tick(3);
        csb = 1'b1; tick(8);
        chk("midrst_no_err", err_count, 0);
        do_frame(16'h61AB, 16, 48, 64'hA5A5_0F0F_C3C3, 0);
        do_io();
        chk("midrst_next_frame", freq_out, 64'hA5A5_0F0F_C3C3);

        // randomized frames
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 7);
            pl   = {$urandom, $urandom};
            ib   = 16;
            case (kind)
                0: begin ins = 16'h61AB; plen = 48; end
                1: begin ins = 16'h21AD; plen = 16; end
                2: begin ins = 16'h240C; plen = 16; end
                3: begin ins = ($urandom_range(0, 1) != 0) ? 16'h61AB : 16'h240C;
                         plen = (ins == 16'h61AB ? 48 : 16) - 1 - $urandom_range(0, 10); end
                4: begin ins = ($urandom_range(0, 1) != 0) ? 16'h61AB : 16'h21AD;
                         plen = (ins == 16'h61AB ? 48 : 16) + 1 + $urandom_range(0, 2); end
                5: begin ins = 16'hA1AD; plen = 16; end
                6: begin ins = ($urandom_range(0, 1) != 0) ? 16'h61AD : {3'b001, 13'h0AAA}; plen = 16; end
                default: begin ins = 16'h240C; ib = $urandom_range(0, 15); plen = 0; end
            endcase
            do_frame(ins, ib, plen, pl, (kind <= 2) && ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) do_io();
        end
        do_io();
        chk("rand_freq", freq_out, m_fout);
        chk("rand_phase", phase_out, m_pout);
        chk("rand_amp", amp_out, m_aout);

        // drive the error counter into saturation
        for (int n = 0; n < 260; n++) do_frame(16'h0000, 2, 0, 64'h0, 0);
        chk("err_saturate", err_count, 255);

        tick(20);
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    function automatic logic ins_freq(input int i);
        logic [15:0] w;
        w = 16'h61AB;
        return w[15-i];
    endfunction

endmodule
